// File: rtl/crc_scan_pkg.sv
// crc_scan_pkg: FSM encoding, CRC constants and SRAM timing shared by crc_scan_ctrl
// and its CRC datapath.
package crc_scan_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } scan_state_e;

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
  localparam int          SRAM_RD_LAT = 1;

endpackage

// File: rtl/crc_scan_ctrl_if.sv
// crc_scan_ctrl_if: host access bus plus the 1RW SRAM macro port. The controller
// uses the slave view; the host/SRAM side (or a bench) uses the master view.
interface crc_scan_ctrl_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                  host_req;
  logic                  host_we;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [DATA_WIDTH-1:0] host_wdata;
  logic                  host_ready;
  logic                  host_rvalid;
  logic [DATA_WIDTH-1:0] host_rdata;

  logic                  sram_csb;
  logic                  sram_web;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH:0]   sram_din;
  logic [DATA_WIDTH:0]   sram_dout;

  modport slave (
    input  host_req, host_we, host_addr, host_wdata, sram_dout,
    output host_ready, host_rvalid, host_rdata,
           sram_csb, sram_web, sram_addr, sram_din
  );

  modport master (
    output host_req, host_we, host_addr, host_wdata, sram_dout,
    input  host_ready, host_rvalid, host_rdata,
           sram_csb, sram_web, sram_addr, sram_din
  );
endinterface

// File: rtl/crc_scan_ctrl_crc32.sv
// crc_scan_ctrl_crc32: one 32-bit word of CRC-32/MPEG-2 (MSB first, no reflection,
// no final xor) folded into a running CRC, purely combinational.
module crc_scan_ctrl_crc32
  import crc_scan_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [31:0] init_i,
  output logic [31:0] crc_o
);

  logic [31:0] stage [0:32];

  assign stage[0] = init_i;

  // One LFSR step per data bit, data_i[31] consumed first.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_bit
      assign stage[gi+1] = {stage[gi][30:0], 1'b0}
                         ^ ({32{stage[gi][31] ^ data_i[31-gi]}} & CRC_POLY);
    end
  endgenerate

  assign crc_o = stage[32];

endmodule

// File: rtl/crc_scan_ctrl.sv
// crc_scan_ctrl: shares one 1RW SRAM port between a host and a CRC-32/MPEG-2 range
// scan with expected-value compare. Define CRC_SCAN_ABORT_EN for the abort/aborted pair.
module crc_scan_ctrl #(
  parameter int          ADDR_WIDTH = 10,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] CRC_INIT   = crc_scan_pkg::CRC_INIT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_cnt,
  input  logic [31:0]           expected_crc,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           crc_result,
  output logic                  match,
`ifdef CRC_SCAN_ABORT_EN
  input  logic                  abort,
  output logic                  aborted,
`endif
  crc_scan_ctrl_if.slave        bus
);

  localparam logic [1:0] ST_IDLE  = crc_scan_pkg::S_IDLE;
  localparam logic [1:0] ST_READ  = crc_scan_pkg::S_READ;
  localparam logic [1:0] ST_DRAIN = crc_scan_pkg::S_DRAIN;
  localparam logic [1:0] ST_DONE  = crc_scan_pkg::S_DONE;
  localparam int         RD_LAT   = crc_scan_pkg::SRAM_RD_LAT;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic [31:0]           exp_q, exp_d;
  logic [31:0]           crc_run_q, crc_run_d;
  logic [31:0]           crc_result_q;
  logic                  match_q;
  logic                  done_q;
  logic                  host_acc;
  logic                  scan_rd;
  logic                  scan_issue;
  logic                  abort_req;
  logic                  abort_hit;
  logic                  capture;
  logic [31:0]           crc_next;
  logic                  scan_pend_q [RD_LAT];
  logic                  host_pend_q [RD_LAT];
  logic                  unused_dout_msb;

`ifdef CRC_SCAN_ABORT_EN
  logic aborted_q;
  assign abort_req = abort;
  assign aborted   = aborted_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) aborted_q <= 1'b0;
    else        aborted_q <= abort_hit;
  end
`else
  assign abort_req = 1'b0;
`endif

  crc_scan_ctrl_crc32 u_crc32 (
    .data_i (bus.sram_dout[31:0]),
    .init_i (crc_run_q),
    .crc_o  (crc_next)
  );

  assign capture    = scan_pend_q[RD_LAT-1];
  assign scan_issue = scan_rd & ~abort_hit;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    exp_d     = exp_q;
    crc_run_d = capture ? crc_next : crc_run_q;
    host_acc  = 1'b0;
    scan_rd   = 1'b0;
    abort_hit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A scan request wins over a same-cycle host access.
        if (start) begin
          addr_d    = base_addr;
          rem_d     = word_cnt;
          exp_d     = expected_crc;
          crc_run_d = CRC_INIT;
          state_d   = (word_cnt == '0) ? ST_DONE : ST_READ;
        end else begin
          host_acc = bus.host_req;
        end
      end
      ST_READ: begin
        scan_rd = 1'b1;
        addr_d  = addr_q + ADDR_WIDTH'(1);
        rem_d   = rem_q - (ADDR_WIDTH+1)'(1);
        if (rem_q == (ADDR_WIDTH+1)'(1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort_req && (state_q == ST_READ || state_q == ST_DRAIN)) begin
      abort_hit = 1'b1;
      state_d   = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      rem_q        <= '0;
      exp_q        <= '0;
      crc_run_q    <= CRC_INIT;
      crc_result_q <= '0;
      match_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      exp_q     <= exp_d;
      crc_run_q <= crc_run_d;
      done_q    <= (state_d == ST_DONE);
      // Result is captured on entry to DONE so it is already valid with done.
      if (state_d == ST_DONE) begin
        crc_result_q <= crc_run_d;
        match_q      <= (crc_run_d == exp_d);
      end
    end
  end

  // Read-return trackers, one stage per cycle of SRAM read latency.
  generate
    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_rd_pipe
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            scan_pend_q[gi] <= 1'b0;
            host_pend_q[gi] <= 1'b0;
          end else begin
            scan_pend_q[gi] <= scan_issue;
            host_pend_q[gi] <= host_acc & ~bus.host_we;
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            scan_pend_q[gi] <= 1'b0;
            host_pend_q[gi] <= 1'b0;
          end else begin
            scan_pend_q[gi] <= scan_pend_q[gi-1];
            host_pend_q[gi] <= host_pend_q[gi-1];
          end
        end
      end
    end
  endgenerate

  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign crc_result = crc_result_q;
  assign match      = match_q;

  assign bus.host_ready  = host_acc;
  assign bus.host_rvalid = host_pend_q[RD_LAT-1];
  assign bus.host_rdata  = bus.sram_dout[DATA_WIDTH-1:0];
  assign bus.sram_csb    = ~(host_acc | scan_rd);
  assign bus.sram_web    = host_acc ? ~bus.host_we : 1'b1;
  assign bus.sram_addr   = host_acc ? bus.host_addr : (scan_rd ? addr_q : '0);
  assign bus.sram_din    = {1'b0, bus.host_wdata};
  assign unused_dout_msb = bus.sram_dout[DATA_WIDTH];

endmodule

// File: doc/crc_scan_ctrl.md
Name: crc_scan_ctrl

Overview:
Sequences the 1RW SRAM macro and the crc32 (CRC-32/MPEG-2) datapath to compute a running CRC over a programmable range of SRAM words. It compares the final CRC against an expected value. It also shares the single SRAM port between a host read/write interface and the scan engine. It sits between the host/test logic and the SRAM, replacing direct host wiring to the macro.

Parameters:
ADDR_WIDTH, 10, SRAM word address width (1024 words).
DATA_WIDTH, 32, payload width; SRAM word is DATA_WIDTH+1, with the MSB always written 0.
CRC_INIT, 32'hFFFF_FFFF, CRC seed loaded on each scan start.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle scan request
base_addr  in  ADDR_WIDTH  first word address of the scan
word_cnt  in  ADDR_WIDTH+1  number of words, 0..2^ADDR_WIDTH
expected_crc  in  32  compare value
busy  out  1  scan in progress
done  out  1  one-cycle pulse when the scan completes
crc_result  out  32  final CRC, held until the next start
match  out  1  crc_result == expected_crc, held with crc_result
host_req  in  1  host access request
host_we  in  1  1=write, 0=read
host_addr  in  ADDR_WIDTH  host address
host_wdata  in  DATA_WIDTH  host write data
host_ready  out  1  host access accepted this cycle
host_rvalid  out  1  host read data valid (one cycle after the accepted read)
host_rdata  out  DATA_WIDTH  sram_dout[DATA_WIDTH-1:0]
sram_csb  out  1  chip select, active-low
sram_web  out  1  write enable, active-low
sram_addr  out  ADDR_WIDTH  SRAM address
sram_din  out  DATA_WIDTH+1  {1'b0, host_wdata}
sram_dout  in  DATA_WIDTH+1  SRAM read data, valid one cycle after the address

Behaviour:
- Reset values: busy=0, done=0, crc_result=0, match=0, host_ready=0, host_rvalid=0, sram_csb=1, sram_web=1, sram_addr=0. FSM resets to IDLE; the running CRC resets to CRC_INIT.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - start=1: latch base_addr, word_cnt and expected_crc; set crc_run=CRC_INIT.
    - word_cnt=0: go to DONE.
    - otherwise: go to READ.
  - start has priority over host_req in the same cycle; host_ready=0 that cycle.
  - Otherwise, host_req=1 gives host_ready=1 combinationally. sram_csb=0, sram_web=~host_we, sram_addr=host_addr.
  - An accepted read raises host_rvalid the next cycle.
- READ:
  - Each cycle drive sram_csb=0, sram_web=1, sram_addr=base+i, for i=0..N-1.
  - The address wraps modulo 2^ADDR_WIDTH.
  - After issuing i=N-1, go to DRAIN.
- Capture: in every cycle following an issued read, crc_run <= crc32(data_in=sram_dout[31:0], init=crc_run).
- DRAIN: capture the last word, then go to DONE.
- DONE:
  - Drive done=1; crc_result=crc_run; match=(crc_run==expected_crc). Both are registered so they are valid in the done cycle.
  - Next state is IDLE.
- Latency: start sampled at T0 gives done at T0+N+2 (N>=1). word_cnt=0 gives done at T0+1 with crc_result=CRC_INIT.
- busy=1 from the cycle after start through the done cycle inclusive.
- While not in IDLE: host_ready=0. The host must hold its request; no request is dropped or queued.
- start while busy is ignored.
- Reset mid-scan: immediate return to IDLE, SRAM deselected, results cleared.

Optional Feature:
CRC_SCAN_ABORT_EN
- Defined:
  - Adds input abort (1 bit) and output aborted (1 bit, reset 0).
  - abort=1 in READ or DRAIN: go to IDLE next cycle and pulse aborted for one cycle.
  - done is not pulsed, and crc_result/match keep their previous values.
  - abort in IDLE or DONE has no effect.
- Undefined: neither port exists; a scan always runs to completion.

Decomposition:
- Package crc_scan_pkg holds:
  - the FSM state enum;
  - CRC_INIT;
  - CRC polynomial constant 32'h04C1_1DB7;
  - a localparam for SRAM read latency (1).
- One sub-module: the existing crc32 combinational block, instantiated once. Its init input is driven by crc_run.

Test Plan:
- Host writes 0x0000_0001..0x0000_0004 to addr 0x010..0x013, then start with base=0x010, cnt=4:
  - done at T0+6;
  - crc_result equals the golden model;
  - match=1 when expected_crc equals the golden value;
  - busy high exactly 6 cycles.
- Wrap: base=0x3FE, cnt=4 reads 0x3FE, 0x3FF, 0x000, 0x001 (check sram_addr sequence); CRC equals the golden model over those words.
- cnt=0: done at T0+1, crc_result=0xFFFF_FFFF; match=1 iff expected_crc=0xFFFF_FFFF.
- host_req held during a scan: host_ready=0 until after done. Same-cycle start+host_req in IDLE: scan wins, host is served on the first IDLE cycle after done.
- Wrong expected_crc (golden ^ 1): match=0. Second start while busy: ignored, no extra done.
- Abort and reset:
  - With CRC_SCAN_ABORT_EN, abort at T0+3 of a cnt=8 scan gives aborted pulse, no done, crc_result unchanged.
  - rst_n low mid-scan clears all outputs immediately.
